// File: rtl/tsr_mac_pkg.sv
// Shared definitions for the dual-channel MAC accumulator: default widths,
// beat-counter sizing and the stage-1 window FSM state type.
package tsr_mac_pkg;

  // Default datapath widths
  localparam int DEF_IN_W  = 17;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_OUT_W = 16;
  localparam int DEF_SHIFT = 8;

  // Beat counter: reports the window length and sticks at all-ones
  localparam int              BEAT_W   = 16;
  localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

  // Stage-1 window tracking: IDLE waits for the first beat, ACCUM adds the rest
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } macState_t;

endpackage

// File: rtl/dual_mac_accum_requant_sat.sv
// Per-channel requantiser: round-half-up arithmetic right shift followed by
// signed saturation to OUT_W bits, with an optional ReLU clamp.
// Optional feature macro: RELU_EN (forces negative results to zero; the
// saturation flag still reports range clipping only).
module requant_sat #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8
) (
  input  logic signed [ACC_W-1:0] i_sum,
  output logic signed [OUT_W-1:0] o_res,
  output logic                    o_sat
);

  // One guard bit keeps the rounding addition from wrapping near the top of
  // the accumulator range.
  localparam int WIDE_W = ACC_W + 1;

  localparam logic signed [WIDE_W-1:0] MAX_V = (WIDE_W'(1) << (OUT_W - 1)) - WIDE_W'(1);
  localparam logic signed [WIDE_W-1:0] MIN_V = ~MAX_V;

  logic signed [WIDE_W-1:0] w_ext;
  logic signed [WIDE_W-1:0] w_rounded;
  logic signed [WIDE_W-1:0] w_clip;
  logic                     w_satFlag;
  logic signed [OUT_W-1:0]  w_final;

  assign w_ext = $signed({i_sum[ACC_W-1], i_sum});

  // With no shift the sum passes straight through; otherwise add half an LSB
  // of the result and shift arithmetically so negative ties round upward.
  generate
    if (SHIFT == 0) begin : gNoShift
      assign w_rounded = w_ext;
    end else begin : gShift
      localparam logic signed [WIDE_W-1:0] HALF = WIDE_W'(1) << (SHIFT - 1);
      assign w_rounded = (w_ext + HALF) >>> SHIFT;
    end
  endgenerate

  // Clip the rounded value into the signed output range and flag any clipping
  always_comb begin
    w_clip    = w_rounded;
    w_satFlag = 1'b0;
    if (w_rounded > MAX_V) begin
      w_clip    = MAX_V;
      w_satFlag = 1'b1;
    end else if (w_rounded < MIN_V) begin
      w_clip    = MIN_V;
      w_satFlag = 1'b1;
    end
  end

`ifdef RELU_EN
  // ReLU after saturation: anything negative becomes zero
  always_comb begin
    w_final = w_clip[OUT_W-1:0];
    if (w_clip[WIDE_W-1]) begin
      w_final = '0;
    end
  end
`else
  // Signed result passed through unchanged
  always_comb begin
    w_final = w_clip[OUT_W-1:0];
  end
`endif

  assign o_res = w_final;
  assign o_sat = w_satFlag;

endmodule

// File: rtl/dual_mac_accum.sv
// Dual-channel window accumulator behind the dual-product multiplier.
// Stage 1 sums each channel's products over an i_last-delimited window
// (bias folded in on the first beat), stage 2 holds the finished sums, and
// stage 3 registers the requantised, saturated results.
// Optional feature macro: RELU_EN (handled inside requant_sat).
module dual_mac_accum
  import tsr_mac_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  input  logic                    i_last,
  input  logic signed [IN_W-1:0]  prod_ac,
  input  logic signed [IN_W-1:0]  prod_bc,
  input  logic signed [ACC_W-1:0] bias_a,
  input  logic signed [ACC_W-1:0] bias_b,
  output logic                    o_valid,
  output logic signed [OUT_W-1:0] o_res_a,
  output logic signed [OUT_W-1:0] o_res_b,
  output logic                    o_sat_a,
  output logic                    o_sat_b,
  output logic [BEAT_W-1:0]       o_beats
);

  // Stage 1: window accumulators
  macState_t                r_state;
  logic signed [ACC_W-1:0]  r_accA;
  logic signed [ACC_W-1:0]  r_accB;
  logic [BEAT_W-1:0]        r_beats;
  logic                     r_winDone;

  // Stage 2: finished window waiting for requantisation
  logic                     r_s2Valid;
  logic signed [ACC_W-1:0]  r_s2SumA;
  logic signed [ACC_W-1:0]  r_s2SumB;
  logic [BEAT_W-1:0]        r_s2Beats;

  // Sign-extended products and requantiser outputs
  logic signed [ACC_W-1:0]  w_prodA;
  logic signed [ACC_W-1:0]  w_prodB;
  logic signed [OUT_W-1:0]  w_resA;
  logic signed [OUT_W-1:0]  w_resB;
  logic                     w_satA;
  logic                     w_satB;

  assign w_prodA = {{(ACC_W-IN_W){prod_ac[IN_W-1]}}, prod_ac};
  assign w_prodB = {{(ACC_W-IN_W){prod_bc[IN_W-1]}}, prod_bc};

  // Window FSM: first beat seeds with bias, later beats accumulate, and a
  // beat carrying i_last raises r_winDone for one cycle so stage 2 can take
  // the sums while a new window starts in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_accA    <= '0;
      r_accB    <= '0;
      r_beats   <= '0;
      r_winDone <= 1'b0;
    end else begin
      r_winDone <= 1'b0;
      if (i_valid) begin
        case (r_state)
          IDLE: begin
            r_accA  <= bias_a + w_prodA;
            r_accB  <= bias_b + w_prodB;
            r_beats <= BEAT_W'(1);
            if (i_last) begin
              r_winDone <= 1'b1;
            end else begin
              r_state <= ACCUM;
            end
          end
          ACCUM: begin
            r_accA <= r_accA + w_prodA;
            r_accB <= r_accB + w_prodB;
            if (r_beats != BEAT_MAX) begin
              r_beats <= r_beats + BEAT_W'(1);
            end
            if (i_last) begin
              r_winDone <= 1'b1;
              r_state   <= IDLE;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  // Stage 2 captures a completed window's sums and beat count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2Valid <= 1'b0;
      r_s2SumA  <= '0;
      r_s2SumB  <= '0;
      r_s2Beats <= '0;
    end else begin
      r_s2Valid <= r_winDone;
      if (r_winDone) begin
        r_s2SumA  <= r_accA;
        r_s2SumB  <= r_accB;
        r_s2Beats <= r_beats;
      end
    end
  end

  requant_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) uRequantA (
    .i_sum (r_s2SumA),
    .o_res (w_resA),
    .o_sat (w_satA)
  );

  requant_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) uRequantB (
    .i_sum (r_s2SumB),
    .o_res (w_resB),
    .o_sat (w_satB)
  );

  // Stage 3 registers the results; they hold until the next strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_res_a <= '0;
      o_res_b <= '0;
      o_sat_a <= 1'b0;
      o_sat_b <= 1'b0;
      o_beats <= '0;
    end else begin
      o_valid <= r_s2Valid;
      if (r_s2Valid) begin
        o_res_a <= w_resA;
        o_res_b <= w_resB;
        o_sat_a <= w_satA;
        o_sat_b <= w_satB;
        o_beats <= r_s2Beats;
      end
    end
  end

endmodule

// File: tb/tb_dual_mac_accum.sv
// Directed testbench for dual_mac_accum: hand-computed vectors covering
// accumulation, rounding, saturation, back-to-back windows, gaps and reset.
// Honours RELU_EN when the design is built with it.
module tb_dual_mac_accum;

  logic               clk;
  logic               rst_n;
  logic               i_valid;
  logic               i_last;
  logic signed [16:0] prod_ac;
  logic signed [16:0] prod_bc;
  logic signed [31:0] bias_a;
  logic signed [31:0] bias_b;
  logic               o_valid;
  logic signed [15:0] o_res_a;
  logic signed [15:0] o_res_b;
  logic               o_sat_a;
  logic               o_sat_b;
  logic [15:0]        o_beats;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  longint qResA[$];
  longint qResB[$];
  longint qSatA[$];
  longint qSatB[$];
  longint qBeats[$];
  longint qCyc[$];

  dual_mac_accum dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_last  (i_last),
    .prod_ac (prod_ac),
    .prod_bc (prod_bc),
    .bias_a  (bias_a),
    .bias_b  (bias_b),
    .o_valid (o_valid),
    .o_res_a (o_res_a),
    .o_res_b (o_res_b),
    .o_sat_a (o_sat_a),
    .o_sat_b (o_sat_b),
    .o_beats (o_beats)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to confirm back-to-back strobes
  always @(posedge clk) cyc <= cyc + 1;

  // Collect every result strobe, sampled mid-cycle
  always @(negedge clk) begin
    if (o_valid) begin
      qResA.push_back(o_res_a);
      qResB.push_back(o_res_b);
      qSatA.push_back(o_sat_a);
      qSatB.push_back(o_sat_b);
      qBeats.push_back(o_beats);
      qCyc.push_back(cyc);
    end
  end

  // Expected result after the optional ReLU stage
  function automatic longint reluExp(input longint x);
`ifdef RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Drive one beat (or an idle cycle) and step past the sampling edge
  task automatic applyStimulus(input logic v, input logic l, input int pa, input int pb,
                               input int ba, input int bb);
    i_valid = v;
    i_last  = l;
    prod_ac = 17'(pa);
    prod_bc = 17'(pb);
    bias_a  = ba;
    bias_b  = bb;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  // Wait (bounded) for one collected result and compare it
  task automatic expectWindow(input string tag, input longint expA, input longint expB,
                              input longint expSatA, input longint expSatB, input longint expBeats);
    for (int k = 0; k < 20 && qResA.size() == 0; k++) @(negedge clk);
    checkOutput({tag, "_present"}, (qResA.size() > 0) ? 1 : 0, 1);
    if (qResA.size() > 0) begin
      checkOutput({tag, "_resA"}, qResA.pop_front(), reluExp(expA));
      checkOutput({tag, "_resB"}, qResB.pop_front(), reluExp(expB));
      checkOutput({tag, "_satA"}, qSatA.pop_front(), expSatA);
      checkOutput({tag, "_satB"}, qSatB.pop_front(), expSatB);
      checkOutput({tag, "_beats"}, qBeats.pop_front(), expBeats);
      void'(qCyc.pop_front());
    end
  endtask

  initial begin
    int rndP[4];
    int rndE[4];
    longint firstCyc;
    longint lastCyc;
    rndP = '{384, -384, 127, 128};
    rndE = '{2, -1, 0, 1};

    rst_n = 1'b0;
    i_valid = 1'b0;
    i_last = 1'b0;
    prod_ac = '0;
    prod_bc = '0;
    bias_a = '0;
    bias_b = '0;
    @(posedge clk);
    #1;
    idleCycles(2);
    @(negedge clk);
    checkOutput("rst_valid", o_valid, 0);
    checkOutput("rst_resA", o_res_a, 0);
    checkOutput("rst_beats", o_beats, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleCycles(1);

    // Four-beat window with latency and hold checks
    applyStimulus(1'b1, 1'b0, 256, -256, 0, 0);
    applyStimulus(1'b1, 1'b0, 256, -256, 0, 0);
    applyStimulus(1'b1, 1'b0, 256, -256, 0, 0);
    applyStimulus(1'b1, 1'b1, 256, -256, 0, 0);
    i_valid = 1'b0;
    i_last  = 1'b0;
    @(negedge clk);
    checkOutput("lat_cycle0", o_valid, 0);
    @(negedge clk);
    checkOutput("lat_cycle1", o_valid, 0);
    @(negedge clk);
    checkOutput("lat_cycle2", o_valid, 1);
    expectWindow("four_beat", 4, -4, 0, 0, 4);
    @(negedge clk);
    checkOutput("strobe_once", o_valid, 0);
    checkOutput("hold_resA", o_res_a, 4);
    #1;
    idleCycles(2);

    // Rounding of single-beat windows
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, rndP[i], rndP[i], 0, 0);
      idleCycles(4);
      expectWindow($sformatf("round_%0d", rndP[i]), rndE[i], rndE[i], 0, 0, 1);
    end

    // Saturation at both ends of the output range
    applyStimulus(1'b1, 1'b1, 0, 0, 32'sd16777216, -32'sd16777216);
    idleCycles(4);
    expectWindow("saturate", 32767, -32768, 1, 1, 1);
    idleCycles(3);
    checkOutput("sat_hold_resA", o_res_a, 32767);

    // Back-to-back single-beat windows
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b1, i, i, 256, 256);
    idleCycles(6);
    checkOutput("b2b_count", qResA.size(), 5);
    if (qCyc.size() == 5) begin
      firstCyc = qCyc[0];
      lastCyc  = qCyc[4];
      checkOutput("b2b_spacing", lastCyc - firstCyc, 4);
    end
    for (int i = 1; i <= 5; i++) expectWindow($sformatf("b2b_%0d", i), 1, 1, 0, 0, 1);

    // Three beats separated by idle gaps
    applyStimulus(1'b1, 1'b0, 300, -500, 10, -20);
    idleCycles(2);
    applyStimulus(1'b1, 1'b0, 300, -500, 10, -20);
    idleCycles(2);
    applyStimulus(1'b1, 1'b1, 300, -500, 10, -20);
    idleCycles(4);
    expectWindow("gaps", 4, -6, 0, 0, 3);

    // Reset in the middle of a window discards it
    applyStimulus(1'b1, 1'b0, 1000, 1000, 0, 0);
    applyStimulus(1'b1, 1'b0, 1000, 1000, 0, 0);
    rst_n = 1'b0;
    idleCycles(1);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_resA", o_res_a, 0);
    #1;
    idleCycles(4);
    checkOutput("midrst_no_valid", qResA.size(), 0);
    applyStimulus(1'b1, 1'b0, 512, -512, 0, 0);
    applyStimulus(1'b1, 1'b1, 512, -512, 0, 0);
    idleCycles(4);
    expectWindow("after_rst", 4, -4, 0, 0, 2);

    // Reset right after a window closes drops it from stage 2
    applyStimulus(1'b1, 1'b1, 768, 768, 0, 0);
    rst_n = 1'b0;
    idleCycles(1);
    rst_n = 1'b1;
    idleCycles(5);
    checkOutput("drop_in_flight", qResA.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
